field_scheduler: RTL and testbench

Owns access to the double-buffered Game of Life field memory and sequences its users. It grants the field to the config loader through the `FCL_controller` handshake, launches generation computations from a run-mode frame divider or a single-step button, and swaps front/back buffers only during display vertical blanking. It sits between the FCL controller/loader, the generation engine and the VGA timing block.

---
 rtl/field_scheduler.sv | 141 ++++++++++++++
 tb/tb_field_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_scheduler.sv
// Arbitrates the double-buffered Life field between the config loader and the generation
// engine; front/back swaps only at vsync. Optional generation watchdog: SCHED_WDOG_EN.
module field_scheduler #(
    parameter int unsigned STEP_DIV    = 30,
    parameter int unsigned GEN_CNT_W   = 16,
    parameter int unsigned WDOG_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_fcl_req,
    input  logic                 i_is_loading,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_vsync,
    input  logic                 i_gen_done,
    output logic                 o_FCL_allowed,
    output logic                 o_gen_start,
    output logic                 o_buf_sel,
    output logic [GEN_CNT_W-1:0] o_gen_count,
    output logic                 o_busy,
    output logic                 o_gen_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FCL_GRANT,
        S_FCL_BUSY,
        S_GEN_RUN,
        S_SWAP_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_pend;
    logic [7:0]           r_div;
    logic                 r_fcl_allowed;
    logic                 r_gen_start;
    logic                 r_buf_sel;
    logic                 r_busy;
    logic [GEN_CNT_W-1:0] r_gen_count;

    logic w_wdog_expire;
    logic w_div_hit;
    logic w_step_req;
    logic w_gen_enter;
    logic w_load_done;
    logic w_swap;
    logic w_wdog_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_fcl_req)   w_next = S_FCL_GRANT;
                else if (r_pend) w_next = S_GEN_RUN;
            end
            S_FCL_GRANT: begin
                if (i_is_loading)    w_next = S_FCL_BUSY;
                else if (!i_fcl_req) w_next = S_IDLE;
            end
            S_FCL_BUSY: begin
                if (!i_is_loading) w_next = S_IDLE;
            end
            S_GEN_RUN: begin
                if (i_gen_done)         w_next = S_SWAP_WAIT;
                else if (w_wdog_expire) w_next = S_IDLE;
            end
            S_SWAP_WAIT: begin
                if (i_vsync) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The divider is frozen while a request is already pending, so requests coalesce.
    assign w_div_hit    = i_run && !r_pend && i_vsync && (r_div == 8'(STEP_DIV - 1));
    assign w_step_req   = (!i_run && i_step) || w_div_hit;
    assign w_gen_enter  = (r_state == S_IDLE) && (w_next == S_GEN_RUN);
    assign w_load_done  = (r_state == S_FCL_BUSY) && !i_is_loading;
    assign w_swap       = (r_state == S_SWAP_WAIT) && i_vsync;
    assign w_wdog_abort = (r_state == S_GEN_RUN) && !i_gen_done && w_wdog_expire;

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fcl_allowed <= 1'b0;
            r_gen_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_buf_sel     <= 1'b0;
            r_gen_count   <= '0;
            r_pend        <= 1'b0;
            r_div         <= '0;
        end else begin
            r_state       <= w_next;
            r_fcl_allowed <= (w_next == S_FCL_GRANT);
            r_gen_start   <= w_gen_enter;
            r_busy        <= (w_next != S_IDLE);
            if (w_swap) r_buf_sel <= ~r_buf_sel;
            if (w_load_done) r_gen_count <= '0;
            else if (w_swap) r_gen_count <= r_gen_count + 1'b1;
            // A fresh request wins over the clear on GEN_RUN entry or load completion.
            if (w_step_req) r_pend <= 1'b1;
            else if (w_gen_enter || w_load_done || w_wdog_abort) r_pend <= 1'b0;
            if (!i_run || r_pend) r_div <= '0;
            else if (i_vsync) r_div <= w_div_hit ? 8'd0 : r_div + 8'd1;
        end
    end

`ifdef SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_gen_err;

    assign w_wdog_expire = (r_state == S_GEN_RUN) && (r_wdog == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog    <= '0;
            r_gen_err <= 1'b0;
        end else begin
            if ((r_state == S_GEN_RUN) && !w_wdog_expire) r_wdog <= r_wdog + 1'b1;
            else r_wdog <= '0;
            if (w_wdog_abort) r_gen_err <= 1'b1;
        end
    end

    assign o_gen_err = r_gen_err;
`else
    assign w_wdog_expire = 1'b0;
    assign o_gen_err     = 1'b0;
`endif

    assign o_FCL_allowed = r_fcl_allowed;
    assign o_gen_start   = r_gen_start;
    assign o_buf_sel     = r_buf_sel;
    assign o_gen_count   = r_gen_count;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_field_scheduler.sv
// Directed bench for field_scheduler: expected output words are queued in order and a
// negedge monitor compares each observed change of the output word against the queue.
module tb_field_scheduler;

    localparam int GEN_CNT_W = 16;
    localparam int W         = GEN_CNT_W + 5;

    logic                 clk;
    logic                 rst_n;
    logic                 i_fcl_req;
    logic                 i_is_loading;
    logic                 i_run;
    logic                 i_step;
    logic                 i_vsync;
    logic                 i_gen_done;
    logic                 o_FCL_allowed;
    logic                 o_gen_start;
    logic                 o_buf_sel;
    logic [GEN_CNT_W-1:0] o_gen_count;
    logic                 o_busy;
    logic                 o_gen_err;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] prev_w = '1;
    int           n_vec  = 0;
    int           n_err  = 0;

    field_scheduler #(
        .STEP_DIV   (3),
        .GEN_CNT_W  (GEN_CNT_W),
        .WDOG_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fcl_req    (i_fcl_req),
        .i_is_loading (i_is_loading),
        .i_run        (i_run),
        .i_step       (i_step),
        .i_vsync      (i_vsync),
        .i_gen_done   (i_gen_done),
        .o_FCL_allowed(o_FCL_allowed),
        .o_gen_start  (o_gen_start),
        .o_buf_sel    (o_buf_sel),
        .o_gen_count  (o_gen_count),
        .o_busy       (o_busy),
        .o_gen_err    (o_gen_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {err, allowed, start, busy, buf_sel, gen_count}
    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] exp_w;
        string        nm;
        cur = {o_gen_err, o_FCL_allowed, o_gen_start, o_busy, o_buf_sel, o_gen_count};
        if (cur !== prev_w) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change: got=%h required=no change (was %h)", cur, prev_w);
            end else begin
                exp_w = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (cur !== exp_w) begin
                    n_err++;
                    $display("FAIL %s: got=%h required=%h", nm, cur, exp_w);
                end
            end
            prev_w = cur;
        end
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_w(input string nm, input bit err, input bit allow, input bit start,
                            input bit busy, input bit bsel, input int cnt);
        exp_q.push_back({err, allow, start, busy, bsel, GEN_CNT_W'(cnt)});
        name_q.push_back(nm);
    endtask

    task automatic pulse_step();
        i_step = 1'b1;
        cyc(1);
        i_step = 1'b0;
    endtask

    task automatic pulse_vsync();
        i_vsync = 1'b1;
        cyc(1);
        i_vsync = 1'b0;
    endtask

    task automatic pulse_done();
        i_gen_done = 1'b1;
        cyc(1);
        i_gen_done = 1'b0;
    endtask

    task automatic drained(input string nm);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: pending=%0d next=%s required pending=0", nm, exp_q.size(), name_q[0]);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        i_fcl_req    = 1'b0;
        i_is_loading = 1'b0;
        i_run        = 1'b0;
        i_step       = 1'b0;
        i_vsync      = 1'b0;
        i_gen_done   = 1'b0;
        expect_w("reset", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        drained("reset_drain");

        // Load handshake, including a withdrawn request
        expect_w("grant", 0, 1, 0, 1, 0, 0);
        i_fcl_req = 1'b1;
        cyc(3);
        expect_w("withdraw", 0, 0, 0, 0, 0, 0);
        i_fcl_req = 1'b0;
        cyc(3);
        expect_w("grant2", 0, 1, 0, 1, 0, 0);
        i_fcl_req = 1'b1;
        cyc(2);
        expect_w("loading", 0, 0, 0, 1, 0, 0);
        i_is_loading = 1'b1;
        cyc(1);
        i_fcl_req = 1'b0;
        cyc(4);
        expect_w("load_done", 0, 0, 0, 0, 0, 0);
        i_is_loading = 1'b0;
        cyc(3);
        drained("load_drain");

        // Ignored inputs: gen_done in IDLE, step while running
        pulse_done();
        i_run = 1'b1;
        pulse_step();
        i_run = 1'b0;
        cyc(4);
        drained("ignored_drain");

        // Single step while paused
        expect_w("step_start", 0, 0, 1, 1, 0, 0);
        expect_w("step_start_end", 0, 0, 0, 1, 0, 0);
        expect_w("step_swap", 0, 0, 0, 0, 1, 1);
        pulse_step();
        cyc(10);
        pulse_done();
        cyc(3);
        pulse_vsync();
        cyc(3);
        drained("step_drain");

        // Run mode, divide by 3, from a fresh reset
        expect_w("reset2", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        expect_w("run_start1", 0, 0, 1, 1, 0, 0);
        expect_w("run_start1_end", 0, 0, 0, 1, 0, 0);
        expect_w("run_swap1", 0, 0, 0, 0, 1, 1);
        expect_w("run_start2", 0, 0, 1, 1, 1, 1);
        expect_w("run_start2_end", 0, 0, 0, 1, 1, 1);
        expect_w("run_swap2", 0, 0, 0, 0, 0, 2);
        expect_w("run_start3", 0, 0, 1, 1, 0, 2);
        expect_w("run_start3_end", 0, 0, 0, 1, 0, 2);
        i_run = 1'b1;
        for (int v = 1; v <= 9; v++) begin
            pulse_vsync();
            cyc(4);
            if (v % 3 == 0) pulse_done();
            cyc(2);
        end
        drained("run_nine_vsync");
        expect_w("run_swap3", 0, 0, 0, 0, 1, 3);
        i_run = 1'b0;
        cyc(1);
        pulse_vsync();
        cyc(3);
        drained("run_drain");

        // FCL request during GEN_RUN waits for the swap; load beats the pending step
        expect_w("pri_start", 0, 0, 1, 1, 1, 3);
        expect_w("pri_start_end", 0, 0, 0, 1, 1, 3);
        pulse_step();
        cyc(3);
        i_fcl_req = 1'b1;
        cyc(2);
        pulse_step();
        cyc(1);
        i_gen_done = 1'b1;
        i_vsync    = 1'b1;
        cyc(1);
        i_gen_done = 1'b0;
        i_vsync    = 1'b0;
        cyc(3);
        drained("done_vsync_same_cycle");
        expect_w("pri_swap", 0, 0, 0, 0, 0, 4);
        expect_w("pri_grant", 0, 1, 0, 1, 0, 4);
        pulse_vsync();
        cyc(3);
        expect_w("pri_loading", 0, 0, 0, 1, 0, 4);
        i_is_loading = 1'b1;
        cyc(1);
        i_fcl_req = 1'b0;
        cyc(3);
        expect_w("pri_load_clear", 0, 0, 0, 0, 0, 0);
        i_is_loading = 1'b0;
        cyc(6);
        drained("pri_drain");

        // Step coinciding with GEN_RUN entry keeps the request pending
        expect_w("coin_start1", 0, 0, 1, 1, 0, 0);
        expect_w("coin_start1_end", 0, 0, 0, 1, 0, 0);
        expect_w("coin_swap1", 0, 0, 0, 0, 1, 1);
        expect_w("coin_start2", 0, 0, 1, 1, 1, 1);
        expect_w("coin_start2_end", 0, 0, 0, 1, 1, 1);
        expect_w("coin_swap2", 0, 0, 0, 0, 0, 2);
        i_step = 1'b1;
        cyc(2);
        i_step = 1'b0;
        cyc(3);
        pulse_done();
        cyc(2);
        pulse_vsync();
        cyc(4);
        pulse_done();
        cyc(2);
        pulse_vsync();
        cyc(3);
        drained("coin_drain");

`ifdef SCHED_WDOG_EN
        // Watchdog: no gen_done, abort 16 cycles after entry, buffer untouched
        expect_w("wdog_start", 0, 0, 1, 1, 0, 2);
        expect_w("wdog_start_end", 0, 0, 0, 1, 0, 2);
        expect_w("wdog_abort", 1, 0, 0, 0, 0, 2);
        pulse_step();
        cyc(17);
        drained("wdog_timing");
        cyc(4);
        drained("wdog_drain");
`endif

        cyc(5);
        drained("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
